// File: rtl/gyro_regs_pkg.sv
// Register map, command-byte fields and FSM state type shared by the
// gyro SPI responder and its testbench.
package gyro_regs_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
  localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
  localparam logic [5:0] ADDR_OUT_TEMP  = 6'h26;
  localparam logic [5:0] ADDR_STATUS    = 6'h27;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MS_BIT = 6;

  localparam logic [7:0] CTRL_REG1_RST = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } gyro_state_t;

  function automatic logic is_ctrl(input logic [5:0] a);
    return (a >= ADDR_CTRL_REG1) && (a <= ADDR_CTRL_REG5);
  endfunction

  // CTRL_REG1..5 sit at 0x20..0x24, so the low three address bits index them.
  function automatic logic [2:0] ctrl_idx(input logic [5:0] a);
    return a[2:0];
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-3 slave bit engine: input synchronisers, edge detection,
// MSB-first receive shifter with byte_done pulse and a loadable transmit shifter.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic       sclk_prev, ss_prev;
  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign sclk_rise = ~sclk_prev & sclk_s & ~ss_s;
  assign sclk_fall = sclk_prev & ~sclk_s & ~ss_s;
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign rx_byte   = rx_shift;

  // The ss chain resets to "selected" so a reset taken while ss is held low
  // never produces a false ss fall; the remainder of that frame is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      miso      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      byte_done <= 1'b0;
      if (ss_s) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'h00;
        miso     <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end
        if (tx_load) begin
          tx_shift <= tx_data;
        end else if (sclk_fall) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/gyro_spi_responder.sv
// 3-axis gyro register-map emulator behind an SPI mode-3 slave.
// Optional GYRO_RESP_SNAPSHOT_EN: sample registers frozen at ss fall for the whole frame.
module gyro_spi_responder
  import gyro_regs_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  temp_in,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic        sample_valid,
  output logic [39:0] ctrl_regs,
  output logic        wr_strobe,
  output logic        busy
);

  gyro_state_t     state_q;
  logic            cmd_rw, cmd_ms;
  logic [5:0]      addr_q, next_addr, rd_addr;
  logic [4:0][7:0] ctrl_q;
  logic [7:0]      temp_q, rd_temp, rd_data, rx_byte, tx_data_q;
  logic [15:0]     x_q, y_q, z_q, rd_x, rd_y, rd_z;
  logic            zyxda, zyxor, read_clr;
  logic            tx_load_q, ss_fall, ss_rise, byte_done;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk       (clk),
    .rst_n     (RST),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .tx_load   (tx_load_q),
    .tx_data   (tx_data_q),
    .miso      (miso),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  assign ctrl_regs = ctrl_q;
  assign miso_oe   = busy;
  assign next_addr = cmd_ms ? addr_q + 6'd1 : addr_q;
  // Byte0 reads the address straight off the shifter; later bytes use the advanced pointer.
  assign rd_addr   = (state_q == ST_ADDR) ? rx_byte[5:0] : next_addr;
  assign read_clr  = (state_q == ST_DATA) && byte_done && !ss_rise && cmd_rw
                     && (addr_q == ADDR_OUT_Z_H);

`ifdef GYRO_RESP_SNAPSHOT_EN
  logic [7:0]  temp_snap;
  logic [15:0] x_snap, y_snap, z_snap;
  always_ff @(posedge clk) begin
    if (!RST) begin
      temp_snap <= 8'h00;
      x_snap    <= 16'h0000;
      y_snap    <= 16'h0000;
      z_snap    <= 16'h0000;
    end else if (state_q == ST_IDLE && ss_fall) begin
      temp_snap <= temp_q;
      x_snap    <= x_q;
      y_snap    <= y_q;
      z_snap    <= z_q;
    end
  end
  assign rd_temp = temp_snap;
  assign rd_x    = x_snap;
  assign rd_y    = y_snap;
  assign rd_z    = z_snap;
`else
  assign rd_temp = temp_q;
  assign rd_x    = x_q;
  assign rd_y    = y_q;
  assign rd_z    = z_q;
`endif

  always_comb begin
    rd_data = 8'h00;
    if (is_ctrl(rd_addr)) begin
      rd_data = ctrl_q[ctrl_idx(rd_addr)];
    end else begin
      case (rd_addr)
        ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
        ADDR_OUT_TEMP: rd_data = rd_temp;
        ADDR_STATUS:   rd_data = {zyxor, 3'b000, zyxda, 3'b000};
        ADDR_OUT_X_L:  rd_data = rd_x[7:0];
        ADDR_OUT_X_H:  rd_data = rd_x[15:8];
        ADDR_OUT_Y_L:  rd_data = rd_y[7:0];
        ADDR_OUT_Y_H:  rd_data = rd_y[15:8];
        ADDR_OUT_Z_L:  rd_data = rd_z[7:0];
        ADDR_OUT_Z_H:  rd_data = rd_z[15:8];
        default:       rd_data = 8'h00;
      endcase
    end
  end

  // A new sample outranks a same-cycle clear, so data is never lost silently.
  always_ff @(posedge clk) begin
    if (!RST) begin
      temp_q <= 8'h00;
      x_q    <= 16'h0000;
      y_q    <= 16'h0000;
      z_q    <= 16'h0000;
      zyxda  <= 1'b0;
      zyxor  <= 1'b0;
    end else begin
      if (sample_valid) begin
        temp_q <= temp_in;
        x_q    <= x_in;
        y_q    <= y_in;
        z_q    <= z_in;
      end
      zyxda <= sample_valid | (zyxda & ~read_clr);
      zyxor <= (sample_valid & zyxda) | (zyxor & ~read_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_ms    <= 1'b0;
      addr_q    <= 6'h00;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
      ctrl_q    <= {32'h0000_0000, CTRL_REG1_RST};
    end else begin
      wr_strobe <= 1'b0;
      tx_load_q <= 1'b0;
      if (ss_rise) begin
        state_q <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (ss_fall) begin
            state_q <= ST_ADDR;
            busy    <= 1'b1;
          end
          ST_ADDR: if (byte_done) begin
            cmd_rw  <= rx_byte[CMD_RW_BIT];
            cmd_ms  <= rx_byte[CMD_MS_BIT];
            addr_q  <= rx_byte[5:0];
            state_q <= ST_DATA;
            if (rx_byte[CMD_RW_BIT]) begin
              tx_load_q <= 1'b1;
              tx_data_q <= rd_data;
            end
          end
          ST_DATA: if (byte_done) begin
            if (!cmd_rw && is_ctrl(addr_q)) begin
              ctrl_q[ctrl_idx(addr_q)] <= rx_byte;
              wr_strobe                <= 1'b1;
            end
            addr_q <= next_addr;
            if (cmd_rw) begin
              tx_load_q <= 1'b1;
              tx_data_q <= rd_data;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Self-checking bench for gyro_spi_responder: SPI mode-3 master driver,
// behavioural register-map model and per-scenario checks.
module tb_gyro_spi_responder;

  logic        clk = 1'b0;
  logic        RST, sclk, ss, mosi, miso, miso_oe, sample_valid, wr_strobe, busy;
  logic [7:0]  temp_in;
  logic [15:0] x_in, y_in, z_in;
  logic [39:0] ctrl_regs;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] wr_q[$];

  logic [7:0]  m_ctrl[5];
  logic [7:0]  m_temp;
  logic [15:0] m_x, m_y, m_z;
  logic        m_da, m_or;

  gyro_spi_responder dut (
    .clk          (clk),
    .RST          (RST),
    .sclk         (sclk),
    .ss           (ss),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .temp_in      (temp_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .sample_valid (sample_valid),
    .ctrl_regs    (ctrl_regs),
    .wr_strobe    (wr_strobe),
    .busy         (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ctrl = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    m_temp = 8'h00; m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
    m_da = 1'b0; m_or = 1'b0;
  endtask

  function automatic logic [39:0] model_ctrl_vec();
    return {m_ctrl[4], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
  endfunction

  function automatic logic [7:0] model_reg(input logic [5:0] a);
    if (a == 6'h0F) return 8'hD3;
    if (a >= 6'h20 && a <= 6'h24) return m_ctrl[a - 6'h20];
    case (a)
      6'h26: return m_temp;
      6'h27: return {m_or, 3'b000, m_da, 3'b000};
      6'h28: return m_x[7:0];
      6'h29: return m_x[15:8];
      6'h2A: return m_y[7:0];
      6'h2B: return m_y[15:8];
      6'h2C: return m_z[7:0];
      6'h2D: return m_z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Expected miso bytes of a read frame: command byte reads as zero.
  task automatic model_read(input logic ms, input logic [5:0] addr, input int n);
    logic [5:0] a;
    a = addr;
    exp_q.delete();
    exp_q.push_back(8'h00);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(model_reg(a));
      if (a == 6'h2D) begin m_da = 1'b0; m_or = 1'b0; end
      if (ms) a = a + 6'd1;
    end
  endtask

  task automatic model_write(input logic ms, input logic [5:0] addr);
    logic [5:0] a;
    a = addr;
    foreach (wr_q[k]) begin
      if (a >= 6'h20 && a <= 6'h24) begin
        m_ctrl[a - 6'h20] = wr_q[k];
        exp_strobes++;
      end
      if (ms) a = a + 6'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = tx[i];
      repeat (8) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_read(input logic ms, input logic [5:0] addr, input int n);
    logic [7:0] rx;
    rx_q.delete();
    frame_begin();
    spi_xfer({1'b1, ms, addr}, rx);
    rx_q.push_back(rx);
    for (int j = 0; j < n; j++) begin
      spi_xfer(8'($urandom_range(0, 255)), rx);
      rx_q.push_back(rx);
    end
    frame_end();
  endtask

  task automatic spi_write(input logic ms, input logic [5:0] addr);
    logic [7:0] rx;
    frame_begin();
    spi_xfer({1'b0, ms, addr}, rx);
    foreach (wr_q[k]) spi_xfer(wr_q[k], rx);
    frame_end();
  endtask

  task automatic pulse_sample(input logic [7:0] t, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z);
    @(negedge clk);
    temp_in = t; x_in = x; y_in = y; z_in = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_or = m_or | m_da;
    m_da = 1'b1;
    m_temp = t; m_x = x; m_y = y; m_z = z;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0; ss = 1'b1; sclk = 1'b1; mosi = 1'b0; sample_valid = 1'b0;
    temp_in = 8'h00; x_in = 16'h0; y_in = 16'h0; z_in = 16'h0;
    model_reset();
    repeat (4) @(negedge clk);
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset miso got %b want 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset miso_oe got %b want 0", miso_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset wr_strobe got %b want 0", wr_strobe); end
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL reset ctrl_regs got %h want %h", ctrl_regs, model_ctrl_vec());
    end
    RST = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_who_am_i();
    logic [7:0] got, exp;
    spi_read(1'b0, 6'h0F, 1);
    model_read(1'b0, 6'h0F, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL who_am_i byte got %02h want %02h", got, exp); end
    end
    n_vec++; if (strobe_cnt !== exp_strobes) begin
      n_err++; $display("FAIL who_am_i strobes got %0d want %0d", strobe_cnt, exp_strobes);
    end
  endtask

  task automatic test_write_ctrl();
    logic [7:0] got, exp;
    wr_q = '{8'h0F};
    spi_write(1'b0, 6'h20);
    model_write(1'b0, 6'h20);
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL write_ctrl ctrl_regs got %h want %h", ctrl_regs, model_ctrl_vec());
    end
    n_vec++; if (strobe_cnt !== exp_strobes) begin
      n_err++; $display("FAIL write_ctrl strobes got %0d want %0d", strobe_cnt, exp_strobes);
    end
    spi_read(1'b0, 6'h20, 1);
    model_read(1'b0, 6'h20, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL write_ctrl readback got %02h want %02h", got, exp); end
    end
  endtask

  task automatic test_burst_write();
    wr_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    spi_write(1'b1, 6'h23);
    model_write(1'b1, 6'h23);
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL burst_write ctrl_regs got %h want %h", ctrl_regs, model_ctrl_vec());
    end
    n_vec++; if (strobe_cnt !== exp_strobes) begin
      n_err++; $display("FAIL burst_write strobes got %0d want %0d", strobe_cnt, exp_strobes);
    end
  endtask

  task automatic test_burst_samples();
    logic [7:0] got, exp;
    pulse_sample(8'($urandom_range(0, 255)), 16'h1234, 16'hABCD, 16'h8001);
    spi_read(1'b0, 6'h26, 1);
    model_read(1'b0, 6'h26, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL temp byte got %02h want %02h", got, exp); end
    end
    spi_read(1'b1, 6'h28, 7);
    model_read(1'b1, 6'h28, 7);
    for (int j = 0; exp_q.size() > 0; j++) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL burst_samples byte%0d got %02h want %02h", j, got, exp); end
    end
  endtask

  task automatic test_status();
    logic [7:0] got, exp;
    pulse_sample(8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom), 16'($urandom));
    pulse_sample(8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom), 16'($urandom));
    spi_read(1'b0, 6'h27, 1);
    model_read(1'b0, 6'h27, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL status_set got %02h want %02h", got, exp); end
    end
    spi_read(1'b0, 6'h2D, 1);
    model_read(1'b0, 6'h2D, 1);
    spi_read(1'b0, 6'h27, 1);
    model_read(1'b0, 6'h27, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL status_clr got %02h want %02h", got, exp); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx, got, exp;
    frame_begin();
    spi_xfer(8'h21, rx);
    spi_bits(8'hFF, 5, rx);
    frame_end();
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL abort ctrl_regs got %h want %h", ctrl_regs, model_ctrl_vec());
    end
    n_vec++; if (strobe_cnt !== exp_strobes) begin
      n_err++; $display("FAIL abort strobes got %0d want %0d", strobe_cnt, exp_strobes);
    end
    spi_read(1'b0, 6'h21, 1);
    model_read(1'b0, 6'h21, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL abort readback got %02h want %02h", got, exp); end
    end
    wr_q = '{8'hA5};
    spi_write(1'b0, 6'h22);
    model_write(1'b0, 6'h22);
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL abort next_frame got %h want %h", ctrl_regs, model_ctrl_vec());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx, got, exp;
    frame_begin();
    spi_xfer(8'h8F, rx);
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %b want 0", busy); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid miso_oe got %b want 0", miso_oe); end
    spi_xfer(8'h00, rx);
    n_vec++; if (rx !== 8'h00) begin n_err++; $display("FAIL rst_mid miso byte got %02h want 00", rx); end
    frame_end();
    n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
      n_err++; $display("FAIL rst_mid ctrl_regs got %h want %h", ctrl_regs, model_ctrl_vec());
    end
    spi_read(1'b0, 6'h0F, 1);
    model_read(1'b0, 6'h0F, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rst_mid next_frame got %02h want %02h", got, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    logic [5:0] a;
    logic       ms;
    int         n;
    for (int it = 0; it < 24; it++) begin
      ms = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: pulse_sample(8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          a = 6'($urandom_range(30, 46));
          n = $urandom_range(1, 3);
          wr_q.delete();
          for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom_range(0, 255)));
          spi_write(ms, a);
          model_write(ms, a);
          n_vec++; if (ctrl_regs !== model_ctrl_vec()) begin
            n_err++; $display("FAIL random_write it%0d ctrl_regs got %h want %h", it, ctrl_regs, model_ctrl_vec());
          end
          n_vec++; if (strobe_cnt !== exp_strobes) begin
            n_err++; $display("FAIL random_write it%0d strobes got %0d want %0d", it, strobe_cnt, exp_strobes);
          end
        end
        default: begin
          a = 6'($urandom_range(14, 47));
          n = $urandom_range(1, 4);
          spi_read(ms, a, n);
          model_read(ms, a, n);
          while (exp_q.size() > 0) begin
            exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
            if (got !== exp) begin
              n_err++; $display("FAIL random_read it%0d addr %02h got %02h want %02h", it, a, got, exp);
            end
          end
        end
      endcase
    end
  endtask

  // New sample lands after X_L, X_H, Y_L are already committed to the shifter.
  task automatic test_snapshot();
    logic [7:0] rx, got, exp;
    pulse_sample(8'h11, 16'h1111, 16'h2222, 16'h3333);
`ifdef GYRO_RESP_SNAPSHOT_EN
    exp_q = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
`else
    exp_q = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h55, 8'h66, 8'h66};
`endif
    rx_q.delete();
    frame_begin();
    spi_xfer(8'hE8, rx);
    rx_q.push_back(rx);
    for (int j = 1; j <= 6; j++) begin
      spi_xfer(8'h00, rx);
      rx_q.push_back(rx);
      if (j == 2) pulse_sample(8'h44, 16'h4444, 16'h5555, 16'h6666);
    end
    frame_end();
    m_da = 1'b0; m_or = 1'b0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL snapshot byte%0d got %02h want %02h", j, got, exp); end
    end
    spi_read(1'b0, 6'h27, 1);
    model_read(1'b0, 6'h27, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = rx_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL snapshot status got %02h want %02h", got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_who_am_i();
    test_write_ctrl();
    test_burst_write();
    test_burst_samples();
    test_status();
    test_abort();
    test_reset_mid_frame();
    test_random();
    test_snapshot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
